// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM type, key map and helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ALL_RELEASED = 4'b1111;

    // Hex code per [row][col], row 0 is the top row of the keypad.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Index of the lowest-numbered active-low row; caller guarantees one is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
        logic [1:0] idx;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    // Active-low column drive with exactly one column pulled low.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return 4'(~(4'b0001 << idx));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs, resets to all ones.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; ones at reset read as "nothing pressed".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad matrix and emits one debounced
// key code strobe per press. Define KEYPAD_HISTORY_EN to add the two-digit
// history outputs (digit_new / digit_old) for the multiplexed display.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 24000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
`ifdef KEYPAD_HISTORY_EN
    ,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
`endif
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic [3:0]       rows_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    state_t           state, state_d;
    logic [1:0]       col_idx, col_d;
    logic [1:0]       row_lat, row_d;
    logic [CNT_W-1:0] deb_cnt, cnt_d, cnt_inc;
    logic [3:0]       cols_d;
    logic [3:0]       key_d;
    logic             kv_d;
    logic             held_d;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rows),
        .q       (rows_s)
    );

    assign tick    = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign cnt_inc = deb_cnt + CNT_W'(1);

    // Free-running scan divider, one tick per SCAN_DIV clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Next-state and registered-output decode; all decisions happen on ticks.
    always_comb begin
        state_d = state;
        col_d   = col_idx;
        row_d   = row_lat;
        cnt_d   = deb_cnt;
        key_d   = key;
        kv_d    = 1'b0;

        case (state)
            SCAN: begin
                if (tick) begin
                    if (rows_s != ALL_RELEASED) begin
                        row_d   = lowest_low_row(rows_s);
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_idx + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (!rows_s[row_lat]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
                            key_d   = KEY_MAP[row_lat][col_idx];
                            kv_d    = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        col_d   = col_idx + 2'd1;
                        state_d = SCAN;
                    end
                end
            end
            HELD: begin
                // Only the latched key is watched; other keys cannot strobe.
                if (tick && rows_s[row_lat]) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (tick) begin
                    if (rows_s == ALL_RELEASED) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
                            state_d = SCAN;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        held_d = (state_d == HELD) || (state_d == RELEASE);
        cols_d = col_drive(col_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SCAN;
            col_idx   <= '0;
            row_lat   <= '0;
            deb_cnt   <= '0;
            cols      <= 4'b1110;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_d;
            col_idx   <= col_d;
            row_lat   <= row_d;
            deb_cnt   <= cnt_d;
            cols      <= cols_d;
            key       <= key_d;
            key_valid <= kv_d;
            key_held  <= held_d;
        end
    end

`ifdef KEYPAD_HISTORY_EN
    // Two-deep history of accepted keys, shifted on each strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_new <= '0;
            digit_old <= '0;
        end else if (kv_d) begin
            digit_old <= digit_new;
            digit_new <= key_d;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a keypad
// matrix model (a row reads low when a pressed key sits on the driven column).
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int          MAX_LAT  = (4 + 1 + DEB) * SCAN_DIV + 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;
`ifdef KEYPAD_HISTORY_EN
    logic [3:0] digit_new;
    logic [3:0] digit_old;
`endif

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
`ifdef KEYPAD_HISTORY_EN
        ,
        .digit_new (digit_new),
        .digit_old (digit_old)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Keypad model: pressed bit r*4+c; override drives raw rows directly.
    logic [15:0] pressed = '0;
    logic        ovr_en  = 1'b0;
    logic [3:0]  ovr_rows = 4'b1111;
    logic [3:0]  mat_rows;

    always_comb begin
        mat_rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols[c]) mat_rows[r] = 1'b0;
            end
        end
        rows = ovr_en ? ovr_rows : mat_rows;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_le(input string name, input int act, input int max);
        n_tests++;
        if (act < 1 || act > max) begin
            n_fail++;
            $display("FAIL %s: got %0d expected 1..%0d at %0t", name, act, max, $time);
        end
    endtask

    // Strobe recorder and always-on invariants.
    logic [3:0] strobe_q[$];
    logic       prev_kv = 1'b0;

    always @(negedge clk) begin
        check("cols_one_low", $countones(~cols), 1);
        check("kv_back_to_back", {31'd0, key_valid & prev_kv}, 0);
        if (key_valid) strobe_q.push_back(key);
        prev_kv = key_valid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cols(input logic [3:0] v, input string name);
        int k;
        k = 0;
        while (cols !== v && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, cols, v);
    endtask

    // Bounded wait for a strobe; lat is cycles waited, -1 on timeout.
    task automatic wait_strobe(input int budget, output int lat);
        lat = -1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk);
            #1;
            if (key_valid) begin
                lat = cyc;
                break;
            end
        end
    endtask

    // Press one key for `hold` cycles, report cycles to first strobe.
    task automatic press_key(input int r, input int c, input int hold, output int lat);
        lat = -1;
        pressed[r*4+c] = 1'b1;
        for (int cyc = 1; cyc <= hold; cyc++) begin
            @(posedge clk);
            #1;
            if (key_valid && lat < 0) lat = cyc;
        end
        pressed = '0;
    endtask

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } key_vec_t;

    typedef struct {
        int         cycles;
        logic [3:0] cols;
    } walk_vec_t;

    key_vec_t   kmap [16];
    walk_vec_t  walk [4];
    logic [3:0] codes [16];

    int         lat;
    int         k;
    int         dur;
    bit         tap;
    logic [3:0] model_key;

    initial begin
        codes = '{4'h1, 4'h2, 4'h3, 4'hA,
                  4'h4, 4'h5, 4'h6, 4'hB,
                  4'h7, 4'h8, 4'h9, 4'hC,
                  4'hE, 4'h0, 4'hF, 4'hD};
        for (int i = 0; i < 16; i++) kmap[i] = '{i / 4, i % 4, codes[i]};
        walk[0] = '{4, 4'b1101};
        walk[1] = '{4, 4'b1011};
        walk[2] = '{4, 4'b0111};
        walk[3] = '{4, 4'b1110};

        // Reset with a row held low: outputs stay at reset values.
        reset_n  = 1'b0;
        ovr_en   = 1'b1;
        ovr_rows = 4'b0111;
        wait_cycles(5);
        check("rst_cols", cols, 4'b1110);
        check("rst_key", key, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);

        // Idle column walk after reset release.
        ovr_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (walk[i].cycles) @(posedge clk);
            #1;
            check($sformatf("walk_%0d", i), cols, walk[i].cols);
        end

        // Every key: one strobe, right code, held, release debounced, key kept.
        for (int i = 0; i < 16; i++) begin
            strobe_q.delete();
            press_key(kmap[i].r, kmap[i].c, 40, lat);
            check_le($sformatf("lat_key%0h", kmap[i].code), lat, MAX_LAT);
            check($sformatf("code_key%0h", kmap[i].code), key, kmap[i].code);
            wait_cycles(8);
            check($sformatf("held_key%0h", kmap[i].code), key_held, 1'b1);
            wait_cycles(32);
            check($sformatf("released_key%0h", kmap[i].code), key_held, 1'b0);
            check($sformatf("strobes_key%0h", kmap[i].code), strobe_q.size(), 1);
            check($sformatf("kept_key%0h", kmap[i].code), key, kmap[i].code);
        end
        model_key = 4'hD;

        // Short bounce: r3/c1 low for two debounce ticks only.
        strobe_q.delete();
        wait_cols(4'b1110, "sb_sync");
        pressed[13] = 1'b1;
        wait_cols(4'b1101, "sb_col1");
        wait_cycles(13);
        pressed = '0;
        wait_cycles(5);
        check("sb_rescan_col", cols, 4'b1011);
        check("sb_no_strobe", strobe_q.size(), 0);
        check("sb_key_kept", key, model_key);
        wait_cycles(20);
        press_key(3, 1, 40, lat);
        check_le("sb_full_lat", lat, MAX_LAT);
        check("sb_full_key", key, 4'h0);
        wait_cycles(40);
        check("sb_full_strobes", strobe_q.size(), 1);

        // Release bounce on 'A': release 1 tick, press 1 tick, then release.
        strobe_q.delete();
        pressed[3] = 1'b1;
        wait_strobe(60, lat);
        check_le("rb_lat", lat, 60);
        wait_cycles(8);
        pressed = '0;
        wait_cycles(4);
        pressed[3] = 1'b1;
        wait_cycles(4);
        pressed = '0;
        wait_cycles(8);
        check("rb_held", key_held, 1'b1);
        wait_cycles(32);
        check("rb_released", key_held, 1'b0);
        check("rb_strobes", strobe_q.size(), 1);
        check("rb_key", key, 4'hA);

        // Two keys: rows driven directly, the two keys short rows 1 and 2.
        strobe_q.delete();
        press_key(1, 1, 40, lat);
        check("tk_key5", key, 4'h5);
        ovr_en   = 1'b1;
        ovr_rows = 4'b1001;
        wait_cycles(40);
        ovr_rows = 4'b1011;
        wait_cycles(40);
        check("tk_held_by_9", key_held, 1'b1);
        ovr_rows = 4'b1111;
        wait_cycles(8);
        check("tk_still_held", key_held, 1'b1);
        wait_cycles(32);
        check("tk_released", key_held, 1'b0);
        check("tk_strobes", strobe_q.size(), 1);
        check("tk_key", key, 4'h5);
        ovr_en = 1'b0;
        wait_cycles(20);

        // Randomized presses vs. a press-level model: long press strobes once
        // with the mapped code, a tap of at most two ticks never strobes.
        model_key = 4'h5;
        for (int it = 0; it < 24; it++) begin
            k   = int'($urandom_range(0, 15));
            tap = ($urandom_range(0, 3) == 0);
            dur = tap ? int'($urandom_range(1, 8)) : int'($urandom_range(40, 70));
            strobe_q.delete();
            if (!tap) model_key = kmap[k].code;
            press_key(kmap[k].r, kmap[k].c, dur, lat);
            wait_cycles(int'($urandom_range(40, 60)));
            check($sformatf("rnd%0d_strobes", it), strobe_q.size(), tap ? 0 : 1);
            if (!tap && strobe_q.size() > 0)
                check($sformatf("rnd%0d_code", it), strobe_q[0], kmap[k].code);
            check($sformatf("rnd%0d_key", it), key, model_key);
            check($sformatf("rnd%0d_idle", it), key_held, 1'b0);
        end

        // History (when present), then reset while 'D' is held.
        press_key(0, 2, 40, lat);
        wait_cycles(40);
        check("h_key3", key, 4'h3);
        pressed[15] = 1'b1;
        wait_strobe(60, lat);
        check_le("h_lat_d", lat, 60);
        wait_cycles(8);
        check("h_keyd", key, 4'hD);
`ifdef KEYPAD_HISTORY_EN
        check("h_old", digit_old, 4'h3);
        check("h_new", digit_new, 4'hD);
`endif
        check("mr_held_before", key_held, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_held", key_held, 1'b0);
        check("mr_key", key, 4'h0);
        check("mr_cols", cols, 4'b1110);
`ifdef KEYPAD_HISTORY_EN
        check("mr_old", digit_old, 4'h0);
        check("mr_new", digit_new, 4'h0);
`endif
        wait_cycles(3);
        strobe_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(3);
        check("mr_no_deassert_strobe", strobe_q.size(), 0);
        wait_strobe(MAX_LAT, lat);
        check_le("mr_rescan_lat", lat, MAX_LAT);
        check("mr_rescan_key", key, 4'hD);
        pressed = '0;
        wait_cycles(40);
        check("mr_strobes", strobe_q.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
